// File: rtl/valu_seq_if.sv
// Request/result bundle for valu_seq: operands and op in, registered vector result out.
// Latency: none (wires only); the block behind the slave modport sets all timing.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: master = requester/consumer (drives operands, in_valid, out_ready);
//        slave  = valu_seq (drives in_ready, out_valid, reg_dest, err).
interface valu_seq_if #(
  parameter int VLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [VLEN-1:0] reg_in1;
  logic [VLEN-1:0] reg_in2;
  logic [63:0]     reg_scalar_in;
  logic [3:0]      valu_op;
  logic [2:0]      SEW;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] reg_dest;
  logic            err;

  modport master (
    output in_valid, reg_in1, reg_in2, reg_scalar_in, valu_op, SEW, out_ready,
    input  in_ready, out_valid, reg_dest, err
  );

  modport slave (
    input  in_valid, reg_in1, reg_in2, reg_scalar_in, valu_op, SEW, out_ready,
    output in_ready, out_valid, reg_dest, err
  );
endinterface

// File: rtl/valu_seq.sv
// Sequential vector ALU: elementwise add/sub/mul (vv and vx) and one-element-per-clock reductions.
// Latency: result on the accepting edge for elementwise/illegal/single-element ops; reductions take N-1 further edges.
// Backpressure: one request in flight; in_ready only in IDLE, result held stable while out_ready is low.
// Ports: clk, rst_n (async active-low), bus (valu_seq_if.slave: request operands + handshake, result + err).
module valu_seq #(
  parameter int VLEN = 64
) (
  input logic       clk,
  input logic       rst_n,
  valu_seq_if.slave bus
);

  localparam int NMAX = VLEN / 4;
  localparam int IDXW = $clog2(NMAX) + 1;

  localparam logic [3:0] OP_SMIN = 4'd6;
  localparam logic [3:0] OP_SMAX = 4'd7;
  localparam logic [3:0] OP_SUM  = 4'd8;
  localparam logic [3:0] OP_UMIN = 4'd9;
  localparam logic [3:0] OP_UMAX = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [63:0]     acc_q, acc_d;
  logic [VLEN-1:0] src_q, src_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      sew_q, sew_d;
  logic [VLEN-1:0] dest_q, dest_d;
  logic            err_q, err_d;

  // Element count for a (legal) SEW code: VLEN / (4 << sew).
  function automatic int unsigned n_elems(input logic [2:0] s);
    return VLEN >> (32'(s) + 2);
  endfunction

  // One datapath slice per element width; the active one is picked by SEW below.
  for (genvar g = 0; g < 5; g++) begin : g_w
    localparam int W = 4 << g;
    localparam int N = VLEN / W;

    logic [VLEN-1:0] ew;     // elementwise result from the live request inputs
    logic [63:0]     fold;   // accumulator after folding element[idx_q]
    logic [63:0]     first;  // element 0 of the live reg_in1
    logic [W-1:0]    ea, eb, cur, acc, fold_w;

    always_comb begin
      ew = '0;
      ea = '0;
      eb = '0;
      for (int k = 0; k < N; k++) begin
        ea = bus.reg_in1[k*W +: W];
        // Odd opcodes in the elementwise range are the vx forms.
        eb = bus.valu_op[0] ? bus.reg_scalar_in[W-1:0] : bus.reg_in2[k*W +: W];
        case (bus.valu_op[2:1])
          2'b00:   ew[k*W +: W] = ea + eb;
          2'b01:   ew[k*W +: W] = ea - eb;
          default: ew[k*W +: W] = ea * eb;
        endcase
      end
    end

    always_comb begin
      cur    = src_q[idx_q*W +: W];
      acc    = acc_q[W-1:0];
      fold_w = acc;
      case (op_q)
        OP_SMIN: fold_w = ($signed(cur) < $signed(acc)) ? cur : acc;
        OP_SMAX: fold_w = ($signed(cur) > $signed(acc)) ? cur : acc;
        OP_SUM:  fold_w = cur + acc;
        OP_UMIN: fold_w = (cur < acc) ? cur : acc;
        OP_UMAX: fold_w = (cur > acc) ? cur : acc;
        default: fold_w = acc;
      endcase
      fold = 64'(fold_w);
    end

    assign first = 64'(bus.reg_in1[W-1:0]);
  end

  logic [VLEN-1:0] ew_sel;
  logic [63:0]     first_sel;
  logic [63:0]     fold_sel;

  always_comb begin
    ew_sel    = '0;
    first_sel = '0;
    case (bus.SEW)
      3'd0:    begin ew_sel = g_w[0].ew; first_sel = g_w[0].first; end
      3'd1:    begin ew_sel = g_w[1].ew; first_sel = g_w[1].first; end
      3'd2:    begin ew_sel = g_w[2].ew; first_sel = g_w[2].first; end
      3'd3:    begin ew_sel = g_w[3].ew; first_sel = g_w[3].first; end
      3'd4:    begin ew_sel = g_w[4].ew; first_sel = g_w[4].first; end
      default: begin ew_sel = '0;        first_sel = '0;           end
    endcase
  end

  // The fold path uses the SEW captured with the reduction, not the live input.
  always_comb begin
    fold_sel = '0;
    case (sew_q)
      3'd0:    fold_sel = g_w[0].fold;
      3'd1:    fold_sel = g_w[1].fold;
      3'd2:    fold_sel = g_w[2].fold;
      3'd3:    fold_sel = g_w[3].fold;
      3'd4:    fold_sel = g_w[4].fold;
      default: fold_sel = '0;
    endcase
  end

  logic            req_legal;
  logic            req_red;
  logic [IDXW-1:0] last_idx;

  assign req_legal = (bus.SEW <= 3'd4) && (bus.valu_op <= OP_UMAX);
  assign req_red   = (bus.valu_op >= OP_SMIN);
  assign last_idx  = IDXW'(n_elems(sew_q) - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    src_d   = src_q;
    op_d    = op_q;
    sew_d   = sew_q;
    dest_d  = dest_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (!req_legal) begin
            dest_d  = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (!req_red) begin
            dest_d  = ew_sel;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (n_elems(bus.SEW) == 1) begin
            // A single-element reduction is the element itself.
            dest_d  = VLEN'(first_sel);
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            acc_d   = first_sel;
            idx_d   = IDXW'(1);
            src_d   = bus.reg_in1;
            op_d    = bus.valu_op;
            sew_d   = bus.SEW;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        acc_d = fold_sel;
        if (idx_q == last_idx) begin
          dest_d  = VLEN'(fold_sel);
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      src_q   <= '0;
      op_q    <= '0;
      sew_q   <= '0;
      dest_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      src_q   <= src_d;
      op_q    <= op_d;
      sew_q   <= sew_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.reg_dest  = dest_q;
  assign bus.err       = err_q;

endmodule

// File: doc/valu_seq.md
# valu_seq

Parametrised, sequential successor to the combinational vector ALU in the vector execute stage. It performs elementwise vector-vector and vector-scalar add, sub and mul at selectable element width (SEW) over a VLEN-bit register. It also performs true multi-cycle reductions (signed/unsigned min, max, sum) that fold one element per clock. Operands enter and results leave through valid/ready handshakes, so the block sits between the vector register-file read port and the writeback arbiter.

## Interface
- VLEN, 64, vector register width in bits; legal values are powers of two ≥ 64

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- reg_in1  in  VLEN  vector operand 1
- reg_in2  in  VLEN  vector operand 2 (elementwise vv ops only)
- reg_scalar_in  in  64  scalar operand; low SEW bits are broadcast
- valu_op  in  4  operation code (see Operation)
- SEW  in  3  element width: 000=4, 001=8, 010=16, 011=32, 100=64 bits; 101–111 illegal
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- reg_dest  out  VLEN  registered result
- err  out  1  illegal valu_op or SEW for the current result

## Operation
- Number of elements N = VLEN / width(SEW). Element k occupies bits [k·w +: w].
- Elementwise ops:
  - valu_op 0000 = vv add, 0001 = vx add, 0010 = vv sub, 0011 = vx sub, 0100 = vv mul, 0101 = vx mul.
  - Results wrap modulo 2^w.
  - mul returns the low w bits of the product (identical for signed and unsigned).
- Reduction ops:
  - valu_op 0110 = signed min, 0111 = signed max, 1000 = sum (wraps modulo 2^w), 1001 = unsigned min, 1010 = unsigned max.
  - Reductions use reg_in1 only.
  - The result is placed in element 0; all other reg_dest bits are 0.
- Illegal requests: valu_op 1011–1111 or SEW 101–111.
  - The request is still accepted.
  - Result is reg_dest = 0, err = 1.
  - Latency equals that of an elementwise op.
- Operand capture:
  - reg_in1, reg_in2, reg_scalar_in, valu_op and SEW are captured at acceptance.
  - Inputs may change freely afterwards.
- State machine IDLE / BUSY / DONE:
  - IDLE: in_ready = 1. On in_valid, the request is accepted:
    - elementwise, illegal, or reduction with N = 1 → result written, go to DONE;
    - reduction with N ≥ 2 → accumulator = element 0, index = 1, go to BUSY.
  - BUSY: each edge folds element[index] into the accumulator and increments the index. When the folded index is N−1, the accumulator is written to reg_dest and the state goes to DONE.
  - DONE: out_valid = 1. If out_ready = 1, go to IDLE at the edge.
- in_ready = (state == IDLE). No request overlaps another, so in_ready is never high in BUSY or DONE.
- reg_dest and err change only on the edge that enters DONE. They hold their value otherwise, including in IDLE after the handshake.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - state = IDLE, index = 0, accumulator = 0;
  - reg_dest = 0, err = 0, out_valid = 0, in_ready = 1.
- Reset mid-operation: the operation is dropped, no result is produced, and the reset values above apply.
- Latency, counted from the accepting edge to out_valid high:
  - 1 edge for elementwise ops, illegal requests, or N = 1;
  - N−1 edges for reductions with N ≥ 2. Example: VLEN = 64, SEW = 001 gives 7 edges; SEW = 000 gives 15 edges.
- Back-pressure: while out_valid = 1 and out_ready = 0, reg_dest, err and out_valid stay stable. in_valid is ignored.
- Throughput: at most one result per 2 cycles, because DONE → IDLE costs one edge.
- in_valid asserted in BUSY or DONE is not accepted. The requester must hold it until in_ready is high.

## Test plan
- VLEN = 64, vv add, SEW = 001, reg_in1 = 0xFF01_0203_0405_0607, reg_in2 = 0x0101_0101_0101_0101 → reg_dest = 0x0002_0304_0506_0708, err = 0, out_valid 1 edge after accept.
- vx mul, SEW = 010, reg_in1 = 0x0003_FFFF_0002_8000, reg_scalar_in = 0x2 → reg_dest = 0x0006_FFFE_0004_0000.
- SEW = 001, reg_in1 = 0x7F80_0102_0304_0506:
  - signed min → reg_dest = 0x80;
  - signed max → 0x7F;
  - unsigned max → 0x80;
  - each result arrives with out_valid 7 edges after accept and in_ready = 0 throughout.
- Reduction sum, SEW = 000, reg_in1 = 0x123 → reg_dest = 0x6 after 15 edges. Repeat with rst_n pulsed low at edge 3 → out_valid, reg_dest and err stay 0, in_ready returns to 1, and no result follows.
- Back-pressure: complete vv sub with out_ready = 0 for 5 cycles while in_valid = 1 with new operands → reg_dest and out_valid are stable, the new request is not accepted, and it is accepted on the cycle after out_ready = 1.
- SEW = 111 or valu_op = 1100 → reg_dest = 0, err = 1, out_valid 1 edge after accept. The next legal op clears err.
